grf_wb_port: RTL



---
 rtl/grf_wb_port.sv | 82 ++++++++
 1 files changed

// File: rtl/grf_wb_port.sv
// General register file (32 x DW) with W-to-D read bypass and a committed-write counter.
// Optional simulation trace of committed writes is enabled with the GRF_TRACE_EN macro.
module grf_wb_port #(
  parameter int DW     = 32,
  parameter int BYPASS = 1,
  parameter int CNTW   = 16
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [4:0]      A1,
  input  logic [4:0]      A2,
  output logic [DW-1:0]   RD1,
  output logic [DW-1:0]   RD2,
  input  logic            WE,
  input  logic [4:0]      A3,
  input  logic [DW-1:0]   WD,
  input  logic [31:0]     WPC,
  output logic [CNTW-1:0] wr_count
);

  // $0 has no storage; entries 1..31 only
  logic [DW-1:0]   rf_r [1:31];
  logic [CNTW-1:0] wr_count_r;
  logic            commit_s;
  logic [DW-1:0]   rd1_s;
  logic [DW-1:0]   rd2_s;
  logic            unused_wpc_s;

  assign commit_s     = WE && (A3 != 5'd0);
  assign unused_wpc_s = ^WPC;

  // Register storage and write counter; reset wins over a simultaneous write
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 1; i < 32; i++) begin
        rf_r[i] <= '0;
      end
      wr_count_r <= '0;
    end else if (commit_s) begin
      rf_r[A3]   <= WD;
      wr_count_r <= wr_count_r + CNTW'(1);
    end
  end

  // Read port 1: zero register, then same-cycle bypass, then stored value
  always_comb begin
    rd1_s = '0;
    if (A1 == 5'd0) begin
      rd1_s = '0;
    end else if ((BYPASS == 1) && WE && (A3 == A1)) begin
      rd1_s = WD;
    end else begin
      rd1_s = rf_r[A1];
    end
  end

  // Read port 2: same priority as port 1, fully independent
  always_comb begin
    rd2_s = '0;
    if (A2 == 5'd0) begin
      rd2_s = '0;
    end else if ((BYPASS == 1) && WE && (A3 == A2)) begin
      rd2_s = WD;
    end else begin
      rd2_s = rf_r[A2];
    end
  end

  assign RD1      = rd1_s;
  assign RD2      = rd2_s;
  assign wr_count = wr_count_r;

`ifdef GRF_TRACE_EN
  // Simulation trace of every committed write
  always @(posedge clk) begin
    if (!reset && commit_s) begin
      $display("@%h: $%d <= %h", WPC, A3, WD);
    end
  end
`endif

endmodule
